// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bus plus the UART transmitter write port.
// The master side feeds the arbiter (requesters and transmitter status).
// The slave side is the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQUESTERS = 4
);
    logic [NUM_REQUESTERS-1:0]   req_valid;
    logic [8*NUM_REQUESTERS-1:0] req_data;
    logic [NUM_REQUESTERS-1:0]   req_last;
    logic [NUM_REQUESTERS-1:0]   req_ready;
    logic [7:0]                  tx_data;
    logic                        tx_write_enable;
    logic                        tx_buffer_full;

    modport master (
        output req_valid, req_data, req_last, tx_buffer_full,
        input  req_ready, tx_data, tx_write_enable
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_buffer_full,
        output req_ready, tx_data, tx_write_enable
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte-stream
// requesters. A grant is held until end of frame or until MAX_BURST bytes
// have been accepted. Data path to the transmitter is combinational.
module uart_tx_arbiter #(
    parameter int  NUM_REQUESTERS = 4,
    parameter int  MAX_BURST      = 16,
    localparam int OW             = $clog2(NUM_REQUESTERS),
    localparam int CW             = $clog2(MAX_BURST + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_tx_arbiter_if.slave      bus,
    output logic [OW-1:0]         owner,
    output logic                  busy
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_owner_q, last_owner_d;
    logic [CW-1:0] count_q, count_d;

    logic [OW-1:0] cand;
    logic [OW-1:0] sel_idx;
    logic          sel_found;
    logic          owner_valid;
    logic          owner_last;
    logic [7:0]    owner_data;
    logic          xfer;

    // Round-robin search: first valid requester above last_owner, wrapping.
    always_comb begin
        cand      = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
            cand = OW'((32'(last_owner_q) + k) % NUM_REQUESTERS);
            if (!sel_found && bus.req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Select the current owner's valid/last/byte.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            if (owner_q == OW'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    // Next-state logic and combinational handshake/transmitter outputs.
    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        last_owner_d        = last_owner_q;
        count_d             = count_q;
        bus.req_ready       = '0;
        bus.tx_write_enable = 1'b0;
        bus.tx_data         = '0;
        busy                = 1'b0;
        xfer                = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    owner_d = sel_idx;
                    count_d = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                busy                   = 1'b1;
                bus.req_ready[owner_q] = !bus.tx_buffer_full;
                xfer                   = owner_valid && !bus.tx_buffer_full;
                if (xfer) begin
                    bus.tx_write_enable = 1'b1;
                    bus.tx_data         = owner_data;
                    count_d             = count_q + CW'(1);
                    // End of frame and burst cap share one release path.
                    if (owner_last || (count_q == CW'(MAX_BURST - 1))) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NUM_REQUESTERS - 1);
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
        end
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (4 requesters, burst 16).
// Each table row is one clock cycle: inputs applied after the rising edge,
// outputs compared on the falling edge.
module tb_uart_tx_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] owner;
    logic       busy;

    int n_cmp;
    int n_err;

    uart_tx_arbiter_if #(.NUM_REQUESTERS(4)) bus ();

    uart_tx_arbiter #(
        .NUM_REQUESTERS(4),
        .MAX_BURST(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .owner(owner),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  e_ready;
        logic        e_we;
        logic [7:0]  e_data;
        logic [1:0]  e_owner;
        logic        e_busy;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs[NV];

    task automatic drive(input logic rst, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] l, input logic f);
        reset              = rst;
        bus.req_valid      = v;
        bus.req_data       = d;
        bus.req_last       = l;
        bus.tx_buffer_full = f;
    endtask

    task automatic check_cycle(input string name, input logic [3:0] er, input logic ew,
                               input logic [7:0] ed, input logic [1:0] eo, input logic eb);
        @(negedge clock);
        n_cmp++;
        if ({bus.req_ready, bus.tx_write_enable, bus.tx_data, owner, busy} !== {er, ew, ed, eo, eb}) begin
            n_err++;
            $display("FAIL %s @%0t: got ready=%b we=%b data=%h owner=%0d busy=%b, want ready=%b we=%b data=%h owner=%0d busy=%b",
                     name, $time, bus.req_ready, bus.tx_write_enable, bus.tx_data, owner, busy,
                     er, ew, ed, eo, eb);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // reset held with all requesters valid
        for (int i = 0; i < 5; i++)
            vecs[i] = '{1'b0, 4'hF, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[5]  = '{1'b1, 4'hF, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        // requester 0 owns; it drops valid then sends one byte
        vecs[6]  = '{1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 4'h1, 1'b0, 8'h00, 2'd0, 1'b1};
        vecs[7]  = '{1'b1, 4'h1, 32'h000000A5, 4'h1, 1'b0, 4'h1, 1'b1, 8'hA5, 2'd0, 1'b1};
        vecs[8]  = '{1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        // single 3-byte frame from requester 2
        vecs[9]  = '{1'b1, 4'h4, 32'h00410000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[10] = '{1'b1, 4'h4, 32'h00410000, 4'h0, 1'b0, 4'h4, 1'b1, 8'h41, 2'd2, 1'b1};
        vecs[11] = '{1'b1, 4'h4, 32'h00420000, 4'h0, 1'b0, 4'h4, 1'b1, 8'h42, 2'd2, 1'b1};
        vecs[12] = '{1'b1, 4'h4, 32'h00430000, 4'h4, 1'b0, 4'h4, 1'b1, 8'h43, 2'd2, 1'b1};
        vecs[13] = '{1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0};
        // fairness: reset, then all four send 1-byte frames
        vecs[14] = '{1'b0, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0};
        vecs[15] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[16] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 1'b1};
        vecs[17] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[18] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h2, 1'b1, 8'h11, 2'd1, 1'b1};
        vecs[19] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd1, 1'b0};
        vecs[20] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h4, 1'b1, 8'h12, 2'd2, 1'b1};
        vecs[21] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0};
        vecs[22] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h8, 1'b1, 8'h13, 2'd3, 1'b1};
        vecs[23] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0};
        vecs[24] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 1'b1};
        vecs[25] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[26] = '{1'b1, 4'hF, 32'h13121110, 4'hF, 1'b0, 4'h2, 1'b1, 8'h11, 2'd1, 1'b1};
        // backpressure in a 5-byte frame from requester 3; others shout meanwhile
        vecs[27] = '{1'b1, 4'h8, 32'h51000000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd1, 1'b0};
        vecs[28] = '{1'b1, 4'h8, 32'h51000000, 4'h0, 1'b0, 4'h8, 1'b1, 8'h51, 2'd3, 1'b1};
        vecs[29] = '{1'b1, 4'h8, 32'h52000000, 4'h0, 1'b0, 4'h8, 1'b1, 8'h52, 2'd3, 1'b1};
        for (int i = 30; i < 34; i++)
            vecs[i] = '{1'b1, 4'hF, 32'h53070707, 4'h7, 1'b1, 4'h0, 1'b0, 8'h00, 2'd3, 1'b1};
        vecs[34] = '{1'b1, 4'h8, 32'h53000000, 4'h0, 1'b0, 4'h8, 1'b1, 8'h53, 2'd3, 1'b1};
        vecs[35] = '{1'b1, 4'h8, 32'h54000000, 4'h0, 1'b0, 4'h8, 1'b1, 8'h54, 2'd3, 1'b1};
        vecs[36] = '{1'b1, 4'h8, 32'h55000000, 4'h8, 1'b0, 4'h8, 1'b1, 8'h55, 2'd3, 1'b1};
        vecs[37] = '{1'b1, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0};

        // first edge puts the design into reset before anything is checked
        drive(1'b0, 4'hF, 32'h0, 4'h0, 1'b0);
        @(posedge clock);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].full);
            check_cycle($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_we,
                        vecs[i].e_data, vecs[i].e_owner, vecs[i].e_busy);
        end

        // burst cap: requester 1 streams 20 bytes, requester 2 waits (last_owner = 3)
        drive(1'b1, 4'b0110, {8'h00, 8'hEE, 8'h80, 8'h00}, 4'h0, 1'b0);
        check_cycle("burst_arb", 4'h0, 1'b0, 8'h00, 2'd3, 1'b0);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 4'b0110, {8'h00, 8'hEE, 8'(8'h80 + k), 8'h00}, 4'h0, 1'b0);
            check_cycle($sformatf("burst_r1_%0d", k), 4'b0010, 1'b1, 8'(8'h80 + k), 2'd1, 1'b1);
        end
        drive(1'b1, 4'b0110, {8'h00, 8'hEE, 8'h90, 8'h00}, 4'b0100, 1'b0);
        check_cycle("burst_gap", 4'h0, 1'b0, 8'h00, 2'd1, 1'b0);
        check_cycle("burst_r2", 4'b0100, 1'b1, 8'hEE, 2'd2, 1'b1);
        drive(1'b1, 4'b0010, {8'h00, 8'h00, 8'h90, 8'h00}, 4'h0, 1'b0);
        check_cycle("burst_gap2", 4'h0, 1'b0, 8'h00, 2'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b0010, {8'h00, 8'h00, 8'(8'h90 + k), 8'h00},
                  (k == 3) ? 4'b0010 : 4'b0000, 1'b0);
            check_cycle($sformatf("burst_rest_%0d", k), 4'b0010, 1'b1, 8'(8'h90 + k), 2'd1, 1'b1);
        end
        drive(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
        check_cycle("burst_done", 4'h0, 1'b0, 8'h00, 2'd1, 1'b0);

        // reset mid-frame: requester 2 sends 2 of 4 bytes, then reset
        drive(1'b1, 4'b0100, {8'h00, 8'hC0, 8'h00, 8'h00}, 4'h0, 1'b0);
        check_cycle("rmf_arb", 4'h0, 1'b0, 8'h00, 2'd1, 1'b0);
        check_cycle("rmf_b0", 4'b0100, 1'b1, 8'hC0, 2'd2, 1'b1);
        drive(1'b1, 4'b0100, {8'h00, 8'hC1, 8'h00, 8'h00}, 4'h0, 1'b0);
        check_cycle("rmf_b1", 4'b0100, 1'b1, 8'hC1, 2'd2, 1'b1);
        drive(1'b0, 4'b0101, {8'h00, 8'hC2, 8'h00, 8'h07}, 4'h0, 1'b0);
        check_cycle("rmf_rst_edge", 4'b0100, 1'b1, 8'hC2, 2'd2, 1'b1);
        check_cycle("rmf_in_reset", 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(1'b1, 4'b0101, {8'h00, 8'hC2, 8'h00, 8'h07}, 4'h0, 1'b0);
        check_cycle("rmf_idle", 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
        check_cycle("rmf_restart", 4'b0001, 1'b1, 8'h07, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
